// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_LANES = WORD_W / 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with registered read data.
// Byte-lane write enables are present only when MEM_BYTE_EN_EN is defined.
module mem_array
    import mem_pkg::*;
#(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
`ifdef MEM_BYTE_EN_EN
    input  logic [NUM_LANES-1:0] be_i,
`endif
    output logic [WORD_W-1:0]    rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    // Storage is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (acc_i && we_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
`ifdef MEM_BYTE_EN_EN
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
`else
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (acc_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU MemRd/MemWr request port: one request at a time, programmable
// wait states, one-cycle ready/err pulse. Optional byte lanes via MEM_BYTE_EN_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for mem_rd/mem_wr; request latched on the accepting edge
// ST_WAIT | counting down wait states; access happens on the edge leaving
// ST_RESP | ready (and err if rejected) high for this one cycle
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_W      = 8,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [31:0]          addr,
    input  logic [WORD_W-1:0]    wdata,
`ifdef MEM_BYTE_EN_EN
    input  logic [NUM_LANES-1:0] be,
`endif
    output logic [WORD_W-1:0]    rdata,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [NUM_LANES-1:0] be_q, be_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                req;
    logic                req_bad;
    logic                enter_resp;
    logic                acc_wr;
    logic                acc_bad;
    logic [ADDR_W-1:0]   acc_word;
    logic [WORD_W-1:0]   acc_wdata;
    logic [NUM_LANES-1:0] acc_be;
    logic [NUM_LANES-1:0] be_in;

`ifdef MEM_BYTE_EN_EN
    assign be_in = be;
`else
    assign be_in = '1;
`endif

    assign req     = mem_rd | mem_wr;
    assign req_bad = (|addr[1:0]) | (|(addr >> (ADDR_W + 2))) | (mem_rd & mem_wr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        bad_d      = bad_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        acc_wr     = (op_q == OP_WR);
        acc_bad    = bad_q;
        acc_word   = word_q;
        acc_wdata  = wdata_q;
        acc_be     = be_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = mem_wr ? OP_WR : OP_RD;
                    bad_d   = req_bad;
                    word_d  = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    be_d    = be_in;
                    cnt_d   = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access straight from the live request.
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        acc_wr     = mem_wr;
                        acc_bad    = req_bad;
                        acc_word   = addr[ADDR_W+1:2];
                        acc_wdata  = wdata;
                        acc_be     = be_in;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = enter_resp;
        err_d   = enter_resp & acc_bad;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            bad_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bad_q   <= bad_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    mem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_i   (enter_resp & ~acc_bad),
        .we_i    (acc_wr),
        .addr_i  (acc_word),
        .wdata_i (acc_wdata),
`ifdef MEM_BYTE_EN_EN
        .be_i    (acc_be),
`endif
        .rdata_o (rdata)
    );

    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder (WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance).
module tb_mem_responder;

    localparam int AW = 8;
    localparam int W  = 2;
`ifdef MEM_BYTE_EN_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, busy, err;
`ifdef MEM_BYTE_EN_EN
    logic [3:0]  be;
`endif

    logic        z_rd, z_wr;
    logic [31:0] z_addr, z_wdata;
    logic [31:0] z_rdata;
    logic        z_ready, z_busy, z_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [0:(2**AW)-1];
    logic [31:0] model_rdata;

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W), .INIT_FILE("")) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_EN_EN
        .be(be),
`endif
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_rd(z_rd), .mem_wr(z_wr),
        .addr(z_addr), .wdata(z_wdata),
`ifdef MEM_BYTE_EN_EN
        .be(4'hF),
`endif
        .rdata(z_rdata), .ready(z_ready), .busy(z_busy), .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        logic [3:0]  eff;
        eff = BE_EN ? b : 4'hF;
        r = old;
        for (int i = 0; i < 4; i++) if (eff[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input string name);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          n;
        int          w;
        bit          got;
        exp_err = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0) || (rd && wr);
        w = int'(a[AW+1:2]);
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
`ifdef MEM_BYTE_EN_EN
        be = b;
`endif
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
        n = 1; got = 0;
        while (!got && n <= 20) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b want 1", name, n, busy);
            end
            if (ready === 1'b1) got = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        total++;
        if (!got || n != W + 1) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d (ready seen=%0d)", name, n, W + 1, got);
        end
        if (!exp_err && wr) model_mem[w] = merge(model_mem[w], d, b);
        if (!exp_err && rd) model_rdata = model_mem[w];
        exp_rdata = model_rdata;
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
        total++;
        if (rdata !== exp_rdata) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s after resp: ready=%b busy=%b err=%b want 000", name, ready, busy, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_rd = 0; mem_wr = 0; addr = 0; wdata = 0;
`ifdef MEM_BYTE_EN_EN
        be = 4'hF;
`endif
        z_rd = 0; z_wr = 0; z_addr = 0; z_wdata = 0;
        repeat (3) @(negedge clk);
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset rdata: got %h want 0", rdata); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset ready: got %b want 0", ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", err); end
        total++;
        if (z_rdata !== 32'h0 || z_busy !== 1'b0 || z_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset zero-wait: rdata=%h busy=%b ready=%b want 0", z_rdata, z_busy, z_ready);
        end
        model_rdata = 32'h0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "basic_rd");
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic readback: got %h want deadbeef", rdata); end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic hold: got %h want deadbeef", rdata); end
        end
    endtask

    task automatic test_errors();
        do_req(1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF, "err_init0");
        do_req(1'b1, 1'b0, 32'h12, 32'h0, 4'hF, "err_misaligned_rd");
        do_req(1'b0, 1'b1, 32'h400, 32'hFFFF0000, 4'hF, "err_range_wr");
        do_req(1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF, "err_conflict");
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, "err_chk_word0");
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "err_chk_word4");
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL err no-write word4: got %h want deadbeef", rdata); end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        @(negedge clk);
        mem_rd = 1'b1; addr = 32'h10;
        for (int c = 1; c <= 3 * (W + 2); c++) begin
            @(negedge clk);
            exp_rdy = (c >= W + 1) && ((c - (W + 1)) % (W + 2) == 0);
            total++;
            if (ready !== exp_rdy) begin
                bad++;
                $display("FAIL b2b ready cycle %0d: got %b want %b", c, ready, exp_rdy);
            end
            if (exp_rdy) begin
                total++;
                if (rdata !== model_mem[4]) begin
                    bad++;
                    $display("FAIL b2b rdata cycle %0d: got %h want %h", c, rdata, model_mem[4]);
                end
            end
        end
        mem_rd = 1'b0;
        model_rdata = model_mem[4];
        repeat (W + 3) begin
            @(negedge clk);
            total++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b drained: ready=%b busy=%b want 0 0", ready, busy);
            end
        end
    endtask

    task automatic test_reset_wait();
        do_req(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, "rstw_init");
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        mem_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstw in reset: busy=%b ready=%b rdata=%h want 0 0 0", busy, ready, rdata);
        end
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            total++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstw no pulse: ready=%b busy=%b want 0 0", ready, busy);
            end
        end
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "rstw_readback");
    endtask

    task automatic test_reset_resp();
        do_req(1'b0, 1'b1, 32'h24, 32'h11111111, 4'hF, "rstr_init");
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'h24; wdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_wr = 1'b0;
        repeat (W) @(negedge clk);
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL rstr ready before reset: got %b want 1", ready); end
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstr drop: ready=%b busy=%b want 0 0", ready, busy);
        end
        model_mem[9] = 32'hCAFEF00D;
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 32'h24, 32'h0, 4'hF, "rstr_readback");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          wd, sel, op;
        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "rnd_init");
        for (int k = 0; k < 40; k++) begin
            wd  = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            op  = $urandom_range(0, 9);
            if (sel == 0)      a = 32'(wd * 4 + $urandom_range(1, 3));
            else if (sel == 1) a = 32'(wd * 4) | (32'h1 << $urandom_range(AW + 2, 31));
            else               a = 32'(wd * 4);
            if (op == 0)       do_req(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_both");
            else if (op <= 4)  do_req(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_wr");
            else               do_req(1'b1, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), "rnd_rd");
        end
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        z_wr = 1'b1; z_addr = 32'h0; z_wdata = 32'h8C010004;
        @(negedge clk);
        z_wr = 1'b0;
        total++;
        if (z_ready !== 1'b1 || z_err !== 1'b0 || z_busy !== 1'b1) begin
            bad++;
            $display("FAIL zw write: ready=%b err=%b busy=%b want 1 0 1", z_ready, z_err, z_busy);
        end
        @(negedge clk);
        total++;
        if (z_ready !== 1'b0 || z_busy !== 1'b0) begin
            bad++;
            $display("FAIL zw idle: ready=%b busy=%b want 0 0", z_ready, z_busy);
        end
        z_rd = 1'b1; z_addr = 32'h0;
        @(negedge clk);
        z_rd = 1'b0;
        total++;
        if (z_ready !== 1'b1 || z_rdata !== 32'h8C010004) begin
            bad++;
            $display("FAIL zw read: ready=%b rdata=%h want 1 8c010004", z_ready, z_rdata);
        end
        @(negedge clk);
        z_rd = 1'b1; z_addr = 32'h2;
        @(negedge clk);
        z_rd = 1'b0;
        total++;
        if (z_ready !== 1'b1 || z_err !== 1'b1 || z_rdata !== 32'h8C010004) begin
            bad++;
            $display("FAIL zw misaligned: ready=%b err=%b rdata=%h want 1 1 8c010004", z_ready, z_err, z_rdata);
        end
        @(negedge clk);
    endtask

`ifdef MEM_BYTE_EN_EN
    task automatic test_byte_en();
        do_req(1'b0, 1'b1, 32'h4, 32'h11223344, 4'hF, "be_init");
        do_req(1'b0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, "be_0101");
        do_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "be_read");
        total++;
        if (rdata !== 32'h11BB33DD) begin bad++; $display("FAIL be lanes: got %h want 11bb33dd", rdata); end
        do_req(1'b0, 1'b1, 32'h4, 32'h00000000, 4'b0000, "be_noop");
        do_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "be_noop_read");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_back_to_back();
        test_reset_wait();
        test_reset_resp();
        test_random();
        test_zero_wait();
`ifdef MEM_BYTE_EN_EN
        test_byte_en();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
